// File: rtl/md_issue_pkg.sv
// Shared definitions for the multiply/divide issue controller: FSM encoding,
// exception writeback constants and payload structs.
package md_issue_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned WDOG_W          = 6;
  localparam int unsigned TIMEOUT_CYC_DEF = 48;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [REG_W-1:0]  RSTATUS_REG = 5'd30;
  localparam logic [DATA_W-1:0] EXC_MULT    = 32'd4;
  localparam logic [DATA_W-1:0] EXC_DIV     = 32'd5;

  // Operation captured at accept time
  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  rd;
    logic              is_div;
  } md_req_t;

  // Writeback payload
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              exception;
  } wb_pkt_t;

  // Exception completion: status register gets the cause code of the op kind
  function automatic wb_pkt_t exc_wb(input logic is_div);
    wb_pkt_t pkt;
    pkt.data      = is_div ? EXC_DIV : EXC_MULT;
    pkt.rd        = RSTATUS_REG;
    pkt.exception = 1'b1;
    return pkt;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Execute-stage, multiplier/divider and writeback signals of md_issue_ctrl.
// slave is the controller's view, master the surrounding pipeline/unit view.
interface md_issue_ctrl_if;
  import md_issue_pkg::*;

  logic              x_valid;
  logic              x_is_mult;
  logic              x_is_div;
  logic [DATA_W-1:0] x_opA;
  logic [DATA_W-1:0] x_opB;
  logic [REG_W-1:0]  x_rd;

  logic [DATA_W-1:0] md_opA;
  logic [DATA_W-1:0] md_opB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;

  logic              stall;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;

  modport slave (
    input  x_valid, x_is_mult, x_is_div, x_opA, x_opB, x_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_opA, md_opB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data, wb_exception
  );

  modport master (
    output x_valid, x_is_mult, x_is_div, x_opA, x_opB, x_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_opA, md_opB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data, wb_exception
  );

endinterface

// File: rtl/md_watchdog.sv
// BUSY-cycle watchdog; only built when MD_TIMEOUT_EN is defined.
// expired flags the LIMIT-th consecutive enabled cycle.
`ifdef MD_TIMEOUT_EN
module md_watchdog
  import md_issue_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic expired
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WDOG_W'(1);
    end
  end

  // Combinational so the abort lands on the same edge as a late RDY would
  assign expired = en & (count == WDOG_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/md_issue_ctrl.sv
// Issue controller sequencing one multiply/divide at a time and returning its
// result to writeback. Define MD_TIMEOUT_EN to abort ops stuck in BUSY.
module md_issue_ctrl
  import md_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clock,
  input  logic           reset,
  md_issue_ctrl_if.slave bus
);

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > (1 << WDOG_W)) begin : g_bad_timeout
    $error("md_issue_ctrl: TIMEOUT_CYC must be in 1..64");
  end

  logic [1:0] state, state_d;
  md_req_t    req_q, req_d;
  wb_pkt_t    wb_q, wb_d;
  logic       mult_q, mult_d;
  logic       div_q, div_d;
  logic       wb_valid_q, wb_valid_d;

  logic       req_present_c;
  logic       accept_c;
  logic       is_div_c;
  logic       busy_c;
  logic       abort_c;

  // Both kind bits set resolves to multiply
  assign is_div_c      = bus.x_is_div & ~bus.x_is_mult;
  assign req_present_c = bus.x_valid & (bus.x_is_mult | bus.x_is_div);
  assign accept_c      = req_present_c & ((state == ST_IDLE) | (state == ST_DONE));
  assign busy_c        = (state == ST_BUSY);

`ifdef MD_TIMEOUT_EN
  logic wdog_expired;

  md_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .en      (busy_c),
    .clear   (~busy_c),
    .expired (wdog_expired)
  );

  assign abort_c = wdog_expired;
`else
  assign abort_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      wb_q       <= '0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d    = state;
    req_d      = req_q;
    wb_d       = wb_q;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    wb_valid_d = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          req_d   = '{op_a: bus.x_opA, op_b: bus.x_opB, rd: bus.x_rd, is_div: is_div_c};
          mult_d  = ~is_div_c;
          div_d   = is_div_c;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.md_resultRDY) begin
          state_d    = ST_DONE;
          wb_valid_d = 1'b1;
          if (bus.md_exception) begin
            wb_d = exc_wb(req_q.is_div);
          end else begin
            wb_d = '{data: bus.md_result, rd: req_q.rd, exception: 1'b0};
          end
        end else if (abort_c) begin
          state_d    = ST_DONE;
          wb_valid_d = 1'b1;
          wb_d       = exc_wb(req_q.is_div);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline freeze: in flight, or a request arriving while IDLE/DONE
  assign bus.stall        = (state == ST_START) | busy_c | accept_c;

  assign bus.md_opA       = req_q.op_a;
  assign bus.md_opB       = req_q.op_b;
  assign bus.md_ctrl_MULT = mult_q;
  assign bus.md_ctrl_DIV  = div_q;

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.wb_data      = wb_q.data;
  assign bus.wb_exception = wb_q.exception;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed and randomized bench for md_issue_ctrl; honours MD_TIMEOUT_EN.
module tb_md_issue_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  md_issue_ctrl_if bus();

  md_issue_ctrl #(.TIMEOUT_CYC(48)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  // Expected writeback from the architectural rules
  function automatic exp_t model(input bit mult, input bit div, input logic [4:0] rd,
                                 input logic [31:0] res, input bit exc);
    exp_t e;
    bit   as_div;
    as_div = div && !mult;
    if (exc) begin
      e.rd   = 5'd30;
      e.data = as_div ? 32'd5 : 32'd4;
      e.exc  = 1'b1;
    end else begin
      e.rd   = rd;
      e.data = res;
      e.exc  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mult"},  32'(bus.md_ctrl_MULT), 0);
    chk({tag, "_div"},   32'(bus.md_ctrl_DIV), 0);
    chk({tag, "_wbv"},   32'(bus.wb_valid), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
    chk({tag, "_opA"},   bus.md_opA, 0);
    chk({tag, "_opB"},   bus.md_opB, 0);
    chk({tag, "_wbd"},   bus.wb_data, 0);
    chk({tag, "_wbrd"},  32'(bus.wb_rd), 0);
    chk({tag, "_wbexc"}, 32'(bus.wb_exception), 0);
  endtask

  // Drive one request at the current negedge (DUT in IDLE or DONE) and
  // finish at the negedge inside its DONE cycle.
  task automatic run_op(input bit mult, input bit div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input logic [31:0] res, input bit exc);
    exp_t e;
    bit   as_div;
    as_div = div && !mult;
    e = model(mult, div, rd, res, exc);
    bus.x_valid = 1'b1; bus.x_is_mult = mult; bus.x_is_div = div;
    bus.x_opA = a; bus.x_opB = b; bus.x_rd = rd;
    #1 chk("req_stall", 32'(bus.stall), 1);
    @(negedge clock);
    chk("start_mult",  32'(bus.md_ctrl_MULT), 32'(!as_div));
    chk("start_div",   32'(bus.md_ctrl_DIV), 32'(as_div));
    chk("start_opA",   bus.md_opA, a);
    chk("start_opB",   bus.md_opB, b);
    chk("start_stall", 32'(bus.stall), 1);
    chk("start_wbv",   32'(bus.wb_valid), 0);
    bus.x_valid = 1'b0; bus.x_opA = $urandom(); bus.x_opB = $urandom();
    // RDY while in START must be ignored
    bus.md_resultRDY = 1'($urandom_range(0, 1));
    bus.md_result = $urandom(); bus.md_exception = 1'($urandom_range(0, 1));
    for (int i = 0; i <= lat; i++) begin
      @(negedge clock);
      chk("busy_stall", 32'(bus.stall), 1);
      chk("busy_mult",  32'(bus.md_ctrl_MULT), 0);
      chk("busy_div",   32'(bus.md_ctrl_DIV), 0);
      chk("busy_wbv",   32'(bus.wb_valid), 0);
      chk("busy_opA",   bus.md_opA, a);
      bus.md_resultRDY = (i == lat);
      bus.md_result    = (i == lat) ? res : $urandom();
      bus.md_exception = (i == lat) ? exc : 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    chk("done_wbv",   32'(bus.wb_valid), 1);
    chk("done_rd",    32'(bus.wb_rd), 32'(e.rd));
    chk("done_data",  bus.wb_data, e.data);
    chk("done_exc",   32'(bus.wb_exception), 32'(e.exc));
    chk("done_stall", 32'(bus.stall), 0);
    chk("done_opB",   bus.md_opB, b);
    // RDY while in DONE must be ignored
    bus.md_resultRDY = 1'($urandom_range(0, 1));
    bus.md_exception = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    bus.x_valid = 1'b0;
    #1 chk("idle_stall", 32'(bus.stall), 0);
    @(negedge clock);
    chk("idle_wbv",  32'(bus.wb_valid), 0);
    chk("idle_mult", 32'(bus.md_ctrl_MULT), 0);
    chk("idle_div",  32'(bus.md_ctrl_DIV), 0);
    bus.md_resultRDY = 1'b0;
  endtask

  task automatic no_req_cycle();
    bus.x_valid = 1'b1; bus.x_is_mult = 1'b0; bus.x_is_div = 1'b0;
    #1 chk("noreq_stall", 32'(bus.stall), 0);
    @(negedge clock);
    chk("noreq_mult", 32'(bus.md_ctrl_MULT), 0);
    chk("noreq_div",  32'(bus.md_ctrl_DIV), 0);
    chk("noreq_wbv",  32'(bus.wb_valid), 0);
    bus.x_valid = 1'b0;
    bus.md_resultRDY = 1'b0;
  endtask

  initial begin
    int kind;
    bit as_div;

    reset = 1'b1;
    bus.x_valid = 1'b0; bus.x_is_mult = 1'b0; bus.x_is_div = 1'b0;
    bus.x_opA = '0; bus.x_opB = '0; bus.x_rd = '0;
    bus.md_result = '0; bus.md_exception = 1'b0; bus.md_resultRDY = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;
    idle_cycle();

    // mult 7*6 -> 42 to rd 3
    run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 2, 32'd42, 1'b0);
    idle_cycle();
    // divide by zero -> status register, cause 5
    run_op(1'b0, 1'b1, 32'd10, 32'd0, 5'd9, 1, 32'hDEAD_BEEF, 1'b1);
    idle_cycle();
    // multiply overflow -> status register, cause 4
    run_op(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd12, 0, 32'h0, 1'b1);
    idle_cycle();
    // back-to-back: div accepted in the mult's DONE cycle
    run_op(1'b1, 1'b0, 32'd3, 32'd5, 5'd5, 1, 32'd15, 1'b0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd17, 3, 32'd14, 1'b0);
    idle_cycle();
    // both kind bits -> multiply
    run_op(1'b1, 1'b1, 32'd9, 32'd9, 5'd21, 0, 32'd81, 1'b0);
    no_req_cycle();

    // reset mid-BUSY
    bus.x_valid = 1'b1; bus.x_is_mult = 1'b1; bus.x_is_div = 1'b0;
    bus.x_opA = 32'h1234; bus.x_opB = 32'h5678; bus.x_rd = 5'd7;
    @(negedge clock);
    bus.x_valid = 1'b0; bus.md_resultRDY = 1'b0;
    repeat (2) @(negedge clock);
    chk("midbusy_stall", 32'(bus.stall), 1);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midrst");
    reset = 1'b0;
    bus.md_resultRDY = 1'b1; bus.md_result = 32'h55; bus.md_exception = 1'b0;
    @(negedge clock);
    chk("postrst_wbv",   32'(bus.wb_valid), 0);
    chk("postrst_stall", 32'(bus.stall), 0);
    @(negedge clock);
    chk("postrst_wbv2",  32'(bus.wb_valid), 0);
    bus.md_resultRDY = 1'b0;

`ifdef MD_TIMEOUT_EN
    // RDY never arrives: abort after 48 BUSY cycles
    for (int k = 0; k < 2; k++) begin
      as_div = (k == 1);
      bus.x_valid = 1'b1; bus.x_is_mult = !as_div; bus.x_is_div = as_div;
      bus.x_opA = $urandom(); bus.x_opB = $urandom(); bus.x_rd = 5'd11;
      @(negedge clock);
      chk("to_start_div", 32'(bus.md_ctrl_DIV), 32'(as_div));
      bus.x_valid = 1'b0; bus.md_resultRDY = 1'b0;
      for (int i = 0; i < 48; i++) begin
        @(negedge clock);
        chk("to_busy_stall", 32'(bus.stall), 1);
        chk("to_busy_wbv",   32'(bus.wb_valid), 0);
      end
      @(negedge clock);
      chk("to_wbv",  32'(bus.wb_valid), 1);
      chk("to_exc",  32'(bus.wb_exception), 1);
      chk("to_rd",   32'(bus.wb_rd), 30);
      chk("to_data", bus.wb_data, as_div ? 32'd5 : 32'd4);
      idle_cycle();
    end
`else
    // Without a watchdog BUSY waits for RDY indefinitely
    bus.x_valid = 1'b1; bus.x_is_mult = 1'b0; bus.x_is_div = 1'b1;
    bus.x_opA = 32'd8; bus.x_opB = 32'd2; bus.x_rd = 5'd11;
    @(negedge clock);
    bus.x_valid = 1'b0; bus.md_resultRDY = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      chk("nto_stall", 32'(bus.stall), 1);
      chk("nto_wbv",   32'(bus.wb_valid), 0);
    end
    bus.md_resultRDY = 1'b1; bus.md_result = 32'd4; bus.md_exception = 1'b0;
    @(negedge clock);
    bus.md_resultRDY = 1'b0;
    chk("nto_wbv_done", 32'(bus.wb_valid), 1);
    chk("nto_data",     bus.wb_data, 32'd4);
    chk("nto_rd",       32'(bus.wb_rd), 11);
    idle_cycle();
`endif

    // randomized ops, occasionally back-to-back or non-requests
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        no_req_cycle();
      end else begin
        run_op(kind != 2, kind >= 2, $urandom(), $urandom(), 5'($urandom()),
               $urandom_range(0, 4), $urandom(), $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) idle_cycle();
      end
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
